deserializer: RTL and testbench
===============================

DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port arst_n_i  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port ser_data_i  input  1  serial data bit, MSB of the frame first.
REQ-004 SHALL have port ser_data_val_i  input  1  qualifies ser_data_i; a frame is a contiguous run of valid cycles.
REQ-005 SHALL have port deser_data_o  output  16  reassembled word, MSB-aligned; bits not received are 0.
REQ-006 SHALL have port deser_data_mod_o  output  4  bit count of the word; 0 means 16.
REQ-007 SHALL have port deser_data_val_o  output  1  one-cycle pulse qualifying deser_data_o and deser_data_mod_o.
REQ-008 SHALL have port busy_o  output  1  high while a frame is being collected (state COLLECT).
REQ-009 SHALL have port err_o  output  1  one-cycle pulse on a rejected short frame (see Configuration).

Function
REQ-010 SHALL implement two states: IDLE and COLLECT.
REQ-011 SHALL, in IDLE with ser_data_val_i=1, load bit 15 of the shift register from ser_data_i, set the bit count to 1 and go to COLLECT.
REQ-012 SHALL, in COLLECT with ser_data_val_i=1, store ser_data_i at the next lower bit position and increment the 5-bit bit count.
REQ-013 SHALL, when the 16th bit is sampled at edge k, drive deser_data_val_o=1 and deser_data_mod_o=0 in the cycle after edge k, with the full word on deser_data_o.
REQ-014 SHALL, after the 16th bit, go to IDLE; if ser_data_val_i is still 1 in the next cycle, treat that bit as bit 1 of a new frame, with no gap.
REQ-015 SHALL, in COLLECT with ser_data_val_i=0 and count N<16, end the frame and, in the following cycle, drive deser_data_val_o=1, deser_data_mod_o=N and deser_data_o = received bits in [15:16-N], zeros below.
REQ-016 SHALL allow an end-of-frame emission and a new frame's first bit in the same cycle without losing either.
REQ-017 SHALL hold deser_data_o and deser_data_mod_o stable until the next emission.
REQ-018 SHALL keep deser_data_val_o low in every cycle without an emission; no back-pressure is supported.
REQ-019 SHALL drive busy_o combinationally from the state: 1 in COLLECT, 0 in IDLE.

Reset
REQ-020 SHALL, on arst_n_i=0 and independently of clk_i, clear state to IDLE, the bit count to 0 and the shift register to 0.
REQ-021 SHALL hold all outputs at 0 during reset: deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, err_o=0, busy_o=0.
REQ-022 SHALL discard a partial frame interrupted by reset; no emission occurs for it after release.
REQ-023 SHALL accept a new frame starting on the first rising edge after arst_n_i deasserts.

Configuration
REQ-024 SHALL provide macro DESER_MIN_LEN_CHECK_EN.
REQ-025 SHALL, with DESER_MIN_LEN_CHECK_EN defined, drop frames of 1 or 2 bits: no deser_data_val_o pulse, err_o=1 for one cycle at the slot the emission would have used, and output data and mod unchanged.
REQ-026 SHALL, without DESER_MIN_LEN_CHECK_EN, emit 1- and 2-bit frames normally (mod 1 or 2) and tie err_o to 0.

Verification
REQ-027 SHALL cover a full frame: 16 valid bits of 0xA5C3, MSB first -> one pulse, data 0xA5C3, mod 0, one cycle after the last bit.
REQ-028 SHALL cover a short frame: 5 bits 1,0,1,1,0, then valid low -> data 0xB000, mod 5, pulse one cycle after valid drops.
REQ-029 SHALL cover back-to-back traffic: 16 bits of 0xFFFF immediately followed by 16 bits of 0x0001 -> two pulses 16 cycles apart, data 0xFFFF then 0x0001, both mod 0.
REQ-030 SHALL cover a 2-bit frame 1,1: with the macro -> err_o pulse and no valid pulse; without the macro -> data 0xC000, mod 2.
REQ-031 SHALL cover reset mid-frame: arst_n_i low after 7 bits, then a 3-bit frame 1,1,1 -> only data 0xE000, mod 3 emitted; all outputs 0 during reset.
REQ-032 SHALL cover a one-cycle valid gap: 4 bits, 1 idle cycle, 4 bits -> two emissions with mod 4 each.

Source files
------------

// File: rtl/deserializer.sv
// deserializer: rebuilds 16-bit words from an MSB-first serial bit stream.
// A frame is a contiguous run of ser_data_val_i cycles. A frame is emitted
// when 16 bits are collected or when valid drops after fewer bits.
// Optional: define DESER_MIN_LEN_CHECK_EN to reject 1- and 2-bit frames
// (err_o pulse instead of an emission).
//
// Ports:
//   clk_i            in   clock, rising edge
//   arst_n_i         in   asynchronous active-low reset
//   ser_data_i       in   serial data bit, MSB first
//   ser_data_val_i   in   qualifies ser_data_i
//   deser_data_o     out  [15:0] reassembled word, MSB-aligned, zero-filled
//   deser_data_mod_o out  [3:0]  bit count of the word (0 means 16)
//   deser_data_val_o out  one-cycle pulse qualifying data/mod
//   busy_o           out  high while a frame is being collected
//   err_o            out  one-cycle pulse on a rejected short frame
module deserializer (
  input  logic        clk_i,
  input  logic        arst_n_i,
  input  logic        ser_data_i,
  input  logic        ser_data_val_i,
  output logic [15:0] deser_data_o,
  output logic [3:0]  deser_data_mod_o,
  output logic        deser_data_val_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned MOD_W  = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [MOD_W-1:0]    mod_q, mod_d;
  logic                val_q, val_d;

  logic                emit;
  logic [DATA_W-1:0]   emit_word;
  logic [MOD_W-1:0]    emit_mod;
  logic [MOD_W-1:0]    bit_pos;

`ifdef DESER_MIN_LEN_CHECK_EN
  logic                err_q, err_d;
  logic                emit_short;
`endif

  // Bit position of the incoming bit within the word while collecting.
  assign bit_pos = MOD_W'(DATA_W - 1) - cnt_q[MOD_W-1:0];

  // Next-state, shift register and emission logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    mod_d     = mod_q;
    val_d     = 1'b0;
    emit      = 1'b0;
    emit_word = shreg_q;
    emit_mod  = cnt_q[MOD_W-1:0];
`ifdef DESER_MIN_LEN_CHECK_EN
    err_d      = 1'b0;
    emit_short = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (ser_data_val_i) begin
          shreg_d             = '0;
          shreg_d[DATA_W-1]   = ser_data_i;
          cnt_d               = CNT_W'(1);
          state_d             = COLLECT;
        end
      end
      COLLECT: begin
        if (ser_data_val_i) begin
          shreg_d[bit_pos] = ser_data_i;
          cnt_d            = cnt_q + CNT_W'(1);
          // Last bit of a full word: emit now so the next cycle may start a new frame.
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            emit      = 1'b1;
            emit_word = shreg_d;
            emit_mod  = '0;
            cnt_d     = '0;
            shreg_d   = '0;
            state_d   = IDLE;
          end
        end else begin
          // Valid dropped: close the partial frame.
          emit      = 1'b1;
          emit_word = shreg_q;
          emit_mod  = cnt_q[MOD_W-1:0];
`ifdef DESER_MIN_LEN_CHECK_EN
          emit_short = (cnt_q <= CNT_W'(2));
`endif
          cnt_d     = '0;
          shreg_d   = '0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (emit) begin
`ifdef DESER_MIN_LEN_CHECK_EN
      if (emit_short) begin
        err_d = 1'b1;
      end else begin
        val_d  = 1'b1;
        data_d = emit_word;
        mod_d  = emit_mod;
      end
`else
      val_d  = 1'b1;
      data_d = emit_word;
      mod_d  = emit_mod;
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
`ifdef DESER_MIN_LEN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
`ifdef DESER_MIN_LEN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign deser_data_o     = data_q;
  assign deser_data_mod_o = mod_q;
  assign deser_data_val_o = val_q;
  assign busy_o           = (state_q == COLLECT);
`ifdef DESER_MIN_LEN_CHECK_EN
  assign err_o            = err_q;
`else
  assign err_o            = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: directed frame table, a reset-mid-frame
// sequence and randomized traffic against a queue-based frame model.
module tb_deserializer;

  logic        clk_i          = 1'b0;
  logic        arst_n_i       = 1'b1;
  logic        ser_data_i     = 1'b0;
  logic        ser_data_val_i = 1'b0;
  logic [15:0] deser_data_o;
  logic [3:0]  deser_data_mod_o;
  logic        deser_data_val_o;
  logic        busy_o;
  logic        err_o;

  deserializer dut (
    .clk_i            (clk_i),
    .arst_n_i         (arst_n_i),
    .ser_data_i       (ser_data_i),
    .ser_data_val_i   (ser_data_val_i),
    .deser_data_o     (deser_data_o),
    .deser_data_mod_o (deser_data_mod_o),
    .deser_data_val_o (deser_data_val_o),
    .busy_o           (busy_o),
    .err_o            (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks  = 0;
  int n_pass    = 0;
  int pulse_cnt = 0;
  int err_cnt   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a frame is a run of valid bits, closed at 16 bits or
  // when valid drops; its word is the bits MSB-aligned with zero fill.
  bit          run_q[$];
  logic [15:0] m_data = '0;
  logic [3:0]  m_mod  = '0;

  always @(posedge clk_i) begin : model
    logic        v, d, r, ev, ee, short_f, exp_busy;
    logic [15:0] w;
    int          n;
    v  = ser_data_val_i;
    d  = ser_data_i;
    r  = arst_n_i;
    ev = 1'b0;
    ee = 1'b0;
    n  = 0;
    if (!r) begin
      run_q.delete();
      m_data = '0;
      m_mod  = '0;
    end else if (v) begin
      run_q.push_back(d);
      if (run_q.size() == 16) n = 16;
    end else if (run_q.size() > 0) begin
      n = run_q.size();
    end
    if (n > 0) begin
      w = '0;
      for (int i = 0; i < n; i++) w = {w[14:0], run_q[i]};
      w = w << (16 - n);
      run_q.delete();
`ifdef DESER_MIN_LEN_CHECK_EN
      short_f = (n <= 2);
`else
      short_f = 1'b0;
`endif
      if (short_f) ee = 1'b1;
      else begin
        ev     = 1'b1;
        m_data = w;
        m_mod  = 4'(n % 16);
      end
    end
    exp_busy = (run_q.size() > 0);
    #1;
    check("cycle{busy,err,val,mod,data}",
          64'({busy_o, err_o, deser_data_val_o, deser_data_mod_o, deser_data_o}),
          64'({exp_busy, ee, ev, m_mod, m_data}));
    if (deser_data_val_o) pulse_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic send(input int len, input logic [15:0] w, input int gap);
    for (int i = 0; i < len; i++) begin
      ser_data_val_i = 1'b1;
      ser_data_i     = w[15-i];
      @(negedge clk_i);
    end
    ser_data_val_i = 1'b0;
    ser_data_i     = 1'b0;
    for (int i = 0; i < gap; i++) @(negedge clk_i);
  endtask

  typedef struct {
    int          len;
    logic [15:0] word;
    int          gap;
    int          exp_pulses;
    int          exp_errs;
    logic [15:0] exp_data;
    logic [3:0]  exp_mod;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p0, e0;

    vecs[0] = '{16, 16'hA5C3, 1, 1, 0, 16'hA5C3, 4'd0};
    vecs[1] = '{5,  16'hB000, 1, 1, 0, 16'hB000, 4'd5};
    vecs[2] = '{16, 16'hFFFF, 0, 1, 0, 16'hFFFF, 4'd0};
    vecs[3] = '{16, 16'h0001, 1, 1, 0, 16'h0001, 4'd0};
`ifdef DESER_MIN_LEN_CHECK_EN
    vecs[4] = '{2,  16'hC000, 1, 0, 1, 16'h0001, 4'd0};
`else
    vecs[4] = '{2,  16'hC000, 1, 1, 0, 16'hC000, 4'd2};
`endif
    vecs[5] = '{4,  16'h9000, 1, 1, 0, 16'h9000, 4'd4};
    vecs[6] = '{4,  16'h6000, 3, 1, 0, 16'h6000, 4'd4};

    #1 arst_n_i = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({busy_o, err_o, deser_data_val_o, deser_data_mod_o, deser_data_o}), 64'(0));
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;

    // Directed frames; the first starts on the first edge after release.
    for (int k = 0; k < 7; k++) begin
      p0 = pulse_cnt;
      e0 = err_cnt;
      send(vecs[k].len, vecs[k].word, vecs[k].gap);
      check($sformatf("vec%0d_pulses", k), 64'(pulse_cnt - p0), 64'(vecs[k].exp_pulses));
      check($sformatf("vec%0d_errs", k),   64'(err_cnt - e0),   64'(vecs[k].exp_errs));
      check($sformatf("vec%0d_data", k),   64'(deser_data_o),   64'(vecs[k].exp_data));
      check($sformatf("vec%0d_mod", k),    64'(deser_data_mod_o), 64'(vecs[k].exp_mod));
    end

    // Reset after 7 bits discards the partial frame.
    p0 = pulse_cnt;
    for (int i = 0; i < 7; i++) begin
      ser_data_val_i = 1'b1;
      ser_data_i     = 1'(i % 2);
      @(negedge clk_i);
    end
    check("busy_mid_frame", 64'(busy_o), 64'(1));
    arst_n_i = 1'b0;
    #1;
    check("reset_mid_frame_outputs",
          64'({busy_o, err_o, deser_data_val_o, deser_data_mod_o, deser_data_o}), 64'(0));
    ser_data_val_i = 1'b0;
    repeat (2) @(negedge clk_i);
    arst_n_i = 1'b1;
    send(3, 16'hE000, 2);
    check("after_reset_pulses", 64'(pulse_cnt - p0), 64'(1));
    check("after_reset_data",   64'(deser_data_o),     64'(16'hE000));
    check("after_reset_mod",    64'(deser_data_mod_o), 64'(3));

    // Randomized traffic with alternating valid density and rare resets.
    for (int c = 0; c < 3000; c++) begin
      arst_n_i       = ($urandom_range(0, 299) != 0);
      ser_data_val_i = ($urandom_range(0, 99) < (((c / 200) % 2) != 0 ? 97 : 65));
      ser_data_i     = 1'($urandom);
      @(negedge clk_i);
    end
    arst_n_i       = 1'b1;
    ser_data_val_i = 1'b0;
    repeat (3) @(negedge clk_i);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
